mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low
- Instr  input  32  latched instruction from the datapath IR
- ALUFlags  input  4  NZCV from the ALU, combinational
- PCWrite, MemWrite, RegWrite, IRWrite, RegWriteHi  output  1 each  write enables
- AdrSrc, ALUSrcA  output  1 each  datapath mux selects
- RegSrc, ALUSrcB, ResultSrc, ImmSrc  output  2 each  datapath mux selects
- ALUControl  output  4  ALU operation
- IsMovt, IsMovm  output  1 each  move-immediate qualifiers
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH. Outputs SHALL be functions of the state, Instr and CondEx only.
REQ-004 SHALL hold a 4-bit NZCV register (Flags). CondEx SHALL be the standard ARM condition check of Instr[31:28] against Flags. Code 1110 SHALL always pass; code 1111 SHALL never pass.
REQ-005 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=2, ALUControl=ADD, ResultSrc=2 and PCWrite=1, then go to DECODE.
REQ-006 DECODE SHALL drive ALUSrcA=1, ALUSrcB=2, ALUControl=ADD and ResultSrc=2, then branch on Op=Instr[27:26]:
- Op=01 -> MEMADR
- Op=00 with Instr[25]=0 -> EXECUTER
- Op=00 with Instr[25]=1 -> EXECUTEI
- Op=10 -> BRANCH
- Op=11 -> FETCH (treated as a NOP)
REQ-007 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=1, ImmSrc=01 and ADD. It SHALL go to MEMREAD if Instr[20]=1, otherwise to MEMWRITE.
REQ-008 MEMREAD SHALL drive AdrSrc=1 and ResultSrc=0, then go to MEMWB.
REQ-009 MEMWB SHALL drive ResultSrc=1 and RegWrite=CondEx, then go to FETCH.
REQ-010 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=0, RegSrc[1]=1 and MemWrite=CondEx, then go to FETCH.
REQ-011 EXECUTER SHALL drive ALUSrcA=0 and ALUSrcB=0. EXECUTEI SHALL drive ALUSrcA=0, ALUSrcB=1 and ImmSrc=00. Both SHALL go to ALUWB.
REQ-012 ALUControl encodings SHALL be:
- ADD 0000, SUB 0001, AND 0010, ORR 0011, MOV 0111
- MUL 0100, UMULL 0101, SMULL 0110
- MOVT 1000, MOVM 1001
REQ-013 Data-processing decode SHALL use Instr[24:21]: 0100 ADD, 0010 SUB, 1010 CMP (SUB with no write-back), 0000 AND, 1100 ORR, 1101 MOV.
REQ-014 Multiply SHALL be decoded when Instr[25]=0 and Instr[7:4]=1001:
- Instr[23]=0 -> MUL
- Instr[23:22]=10 -> UMULL
- Instr[23:22]=11 -> SMULL
REQ-015 Instr[27:20]=0x34 SHALL select MOVT with IsMovt=1; Instr[27:20]=0x30 SHALL select MOVM with IsMovm=1. IsMovt and IsMovm SHALL be held for the whole instruction, DECODE through ALUWB, and SHALL be 0 in every other state.
REQ-016 ALUWB SHALL drive ResultSrc=0 and RegWrite=CondEx, with RegWrite forced to 0 for CMP. RegWriteHi SHALL be CondEx for UMULL/SMULL and 0 otherwise.
REQ-017 Flags SHALL update on the final clock edge of EXECUTER/EXECUTEI when Instr[20]=1 and CondEx=1, or for any CMP when CondEx=1:
- N and Z always update.
- C and V update only for ADD, SUB and CMP.
- Multiply and MOVT/MOVM SHALL NOT update C or V.
REQ-018 BRANCH SHALL drive RegSrc[0]=1, ALUSrcA=0, ALUSrcB=1, ImmSrc=10, ADD, ResultSrc=2 and PCWrite=CondEx, then go to FETCH.
REQ-019 Any output not listed for a state SHALL be 0.
REQ-020 A failed condition SHALL suppress only the RegWrite, RegWriteHi, MemWrite, BRANCH PCWrite and flag writes. The state sequence SHALL be unchanged.
REQ-021 Instruction latency SHALL be:
- load: 5 cycles
- store: 4 cycles
- data-processing, multiply and MOVT/MOVM: 4 cycles
- branch: 3 cycles
- Op=11: 2 cycles

Reset
REQ-022 While reset=0:
- state SHALL be forced to FETCH and Flags to 0000, asynchronously;
- PCWrite, MemWrite, RegWrite, RegWriteHi and IRWrite SHALL be 0;
- the other outputs SHALL take their FETCH values.
REQ-023 Reset asserted mid-instruction SHALL abort the instruction with no further write. The first rising edge after release SHALL execute FETCH.

Verification
REQ-024 Release reset -> PCWrite=1 and IRWrite=1 in cycle 1. With Instr=0xE0821003 (ADD) the sequence SHALL be FETCH, DECODE, EXECUTER, ALUWB with RegWrite=1 only in ALUWB.
REQ-025 Instr=0xE5912004 (LDR) -> MEMADR with ImmSrc=01, then MEMREAD with AdrSrc=1, then MEMWB with ResultSrc=1 and RegWrite=1: 5 cycles total.
REQ-026 Flags Z=0 and Instr=0x0A000002 (BEQ) -> BRANCH with PCWrite=0. After a SUBS that sets Z=1, the same BEQ -> PCWrite=1.
REQ-027 Instr=0xE0832291 (UMULL) -> ALUControl=0101 in EXECUTER, and RegWrite=1 with RegWriteHi=1 in ALUWB. MUL 0xE0020091 -> RegWriteHi=0.
REQ-028 Instr=0xE3412234 (MOVT) -> IsMovt=1 from DECODE through ALUWB and ALUControl=1000. Instr=0xE3012234 -> IsMovm=1.
REQ-029 Drive reset=0 in MEMWRITE of 0xE5812000 (STR) -> MemWrite=0 immediately; after release the state SHALL be FETCH and Flags SHALL be 0000.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for a small ARM-style datapath.
// A Moore FSM steps each instruction through FETCH/DECODE and the memory,
// data-processing or branch paths. It also holds the NZCV flag register and
// evaluates the instruction's condition code against it.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low
//   Instr       latched instruction from the datapath IR
//   ALUFlags    NZCV from the ALU (combinational)
//   PCWrite, MemWrite, RegWrite, IRWrite, RegWriteHi   write enables
//   AdrSrc, ALUSrcA, RegSrc, ALUSrcB, ResultSrc, ImmSrc datapath mux selects
//   ALUControl  ALU operation
//   IsMovt, IsMovm  move-immediate qualifiers, held DECODE..ALUWB
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        RegWriteHi,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        IsMovt,
    output logic        IsMovm
);

    typedef enum logic [3:0] {
        s_fetch, s_decode, s_memadr, s_memread, s_memwb,
        s_memwrite, s_executer, s_executei, s_aluwb, s_branch
    } state_t;

    state_t     state;
    logic [3:0] flags;
    logic       condex;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       is_movt, is_movm, is_mul, is_long, is_cmp, cv_update;
    logic [3:0] alu_op;
    logic       in_exec, movx_window;
    logic       unused_instr_bits;

    assign op  = Instr[27:26];
    assign cmd = Instr[24:21];

    // MOVT (0x34) aliases the CMP-immediate encoding, so the move forms and
    // multiply are recognised before the plain data-processing command field.
    assign is_movt   = (Instr[27:20] == 8'h34);
    assign is_movm   = (Instr[27:20] == 8'h30);
    assign is_mul    = (op == 2'b00) && !Instr[25] && (Instr[7:4] == 4'b1001);
    assign is_long   = is_mul && Instr[23];
    assign is_cmp    = !is_movt && !is_movm && !is_mul && (cmd == 4'b1010);
    assign cv_update = !is_movt && !is_movm && !is_mul &&
                       ((cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010));

    assign unused_instr_bits = ^{Instr[19:8], Instr[3:0]};

    always_comb begin
        alu_op = 4'b0000;
        if (is_movt)
            alu_op = 4'b1000;
        else if (is_movm)
            alu_op = 4'b1001;
        else if (is_mul)
            alu_op = Instr[23] ? (Instr[22] ? 4'b0110 : 4'b0101) : 4'b0100;
        else begin
            case (cmd)
                4'b0100: alu_op = 4'b0000;
                4'b0010: alu_op = 4'b0001;
                4'b1010: alu_op = 4'b0001;
                4'b0000: alu_op = 4'b0010;
                4'b1100: alu_op = 4'b0011;
                4'b1101: alu_op = 4'b0111;
                default: alu_op = 4'b0000;
            endcase
        end
    end

    // Flags are {N, Z, C, V}.
    always_comb begin
        case (Instr[31:28])
            4'b0000: condex = flags[2];
            4'b0001: condex = !flags[2];
            4'b0010: condex = flags[1];
            4'b0011: condex = !flags[1];
            4'b0100: condex = flags[3];
            4'b0101: condex = !flags[3];
            4'b0110: condex = flags[0];
            4'b0111: condex = !flags[0];
            4'b1000: condex = flags[1] && !flags[2];
            4'b1001: condex = !flags[1] || flags[2];
            4'b1010: condex = (flags[3] == flags[0]);
            4'b1011: condex = (flags[3] != flags[0]);
            4'b1100: condex = !flags[2] && (flags[3] == flags[0]);
            4'b1101: condex = flags[2] || (flags[3] != flags[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign in_exec     = (state == s_executer) || (state == s_executei);
    assign movx_window = (state == s_decode) || in_exec || (state == s_aluwb);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= s_fetch;
            flags <= '0;
        end else begin
            if (in_exec && condex && (Instr[20] || is_cmp)) begin
                flags[3:2] <= ALUFlags[3:2];
                if (cv_update)
                    flags[1:0] <= ALUFlags[1:0];
            end
            case (state)
                s_fetch:    state <= s_decode;
                s_decode: begin
                    case (op)
                        2'b01:   state <= s_memadr;
                        2'b00:   state <= Instr[25] ? s_executei : s_executer;
                        2'b10:   state <= s_branch;
                        default: state <= s_fetch;
                    endcase
                end
                s_memadr:   state <= Instr[20] ? s_memread : s_memwrite;
                s_memread:  state <= s_memwb;
                s_executer: state <= s_aluwb;
                s_executei: state <= s_aluwb;
                default:    state <= s_fetch;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWriteHi = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        RegSrc     = '0;
        ALUSrcB    = '0;
        ResultSrc  = '0;
        ImmSrc     = '0;
        ALUControl = '0;
        IsMovt     = movx_window && is_movt;
        IsMovm     = movx_window && is_movm;
        case (state)
            s_fetch: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            s_decode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            s_memadr: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b01;
            end
            s_memread: begin
                AdrSrc = 1'b1;
            end
            s_memwb: begin
                ResultSrc = 2'b01;
                RegWrite  = condex;
            end
            s_memwrite: begin
                AdrSrc   = 1'b1;
                RegSrc   = 2'b10;
                MemWrite = condex;
            end
            s_executer: begin
                ALUControl = alu_op;
            end
            s_executei: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            s_aluwb: begin
                RegWrite   = condex && !is_cmp;
                RegWriteHi = condex && is_long;
            end
            s_branch: begin
                RegSrc    = 2'b01;
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = condex;
            end
            default: ;
        endcase
        // Reset holds the FETCH selects but blocks every write.
        if (!reset) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWriteHi = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized self-checking bench for mc_controller.
// A reference model derives each instruction's phase sequence and per-phase
// control word from the instruction fields, and tracks NZCV itself.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, RegWriteHi, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]  ALUControl;
    logic        IsMovt, IsMovm;
    logic [20:0] obs;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [3:0]  mflags   = 4'b0000;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4,
                   P_MW = 5, P_ER = 6, P_EI = 7, P_AWB = 8, P_BR = 9;
    localparam logic [20:0] WEN_MASK = 21'h1F_0000;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .RegWriteHi(RegWriteHi), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .RegSrc(RegSrc), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .IsMovt(IsMovt), .IsMovm(IsMovm)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, RegWriteHi, AdrSrc, ALUSrcA,
                  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl, IsMovt, IsMovm};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_movx(input logic [31:0] ins);
        return (ins[27:20] == 8'h34) || (ins[27:20] == 8'h30);
    endfunction

    function automatic bit is_mulop(input logic [31:0] ins);
        return ins[27:26] == 2'b00 && ins[25] == 1'b0 && ins[7:4] == 4'b1001;
    endfunction

    function automatic bit is_cmpop(input logic [31:0] ins);
        return !is_movx(ins) && !is_mulop(ins) && ins[24:21] == 4'b1010;
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] ins);
        if (ins[27:20] == 8'h34) return 4'b1000;
        if (ins[27:20] == 8'h30) return 4'b1001;
        if (is_mulop(ins)) return !ins[23] ? 4'b0100 : (ins[22] ? 4'b0110 : 4'b0101);
        case (ins[24:21])
            4'b0100: return 4'b0000;
            4'b0010: return 4'b0001;
            4'b1010: return 4'b0001;
            4'b0000: return 4'b0010;
            4'b1100: return 4'b0011;
            4'b1101: return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [20:0] exp_vec(input int ph, input logic [31:0] ins, input logic ce);
        logic pcw, mw, rw, irw, rwh, adr, asa, mt, mm;
        logic [1:0] rs, asb, res, imm;
        logic [3:0] alu;
        {pcw, mw, rw, irw, rwh, adr, asa, mt, mm} = '0;
        {rs, asb, res, imm} = '0;
        alu = '0;
        if (ph == P_D || ph == P_ER || ph == P_EI || ph == P_AWB) begin
            mt = (ins[27:20] == 8'h34);
            mm = (ins[27:20] == 8'h30);
        end
        case (ph)
            P_F:   begin irw = 1; asa = 1; asb = 2; res = 2; pcw = 1; end
            P_D:   begin asa = 1; asb = 2; res = 2; end
            P_MA:  begin asb = 1; imm = 1; end
            P_MR:  begin adr = 1; end
            P_MWB: begin res = 1; rw = ce; end
            P_MW:  begin adr = 1; rs = 2; mw = ce; end
            P_ER:  begin alu = alu_of(ins); end
            P_EI:  begin asb = 1; alu = alu_of(ins); end
            P_AWB: begin rw = ce && !is_cmpop(ins); rwh = ce && is_mulop(ins) && ins[23]; end
            P_BR:  begin rs = 1; asb = 1; imm = 2; res = 2; pcw = ce; end
            default: ;
        endcase
        return {pcw, mw, rw, irw, rwh, adr, asa, rs, asb, res, imm, alu, mt, mm};
    endfunction

    // Runs one instruction from its FETCH cycle. If abort_at >= 0, reset is
    // asserted in that phase instead and the instruction is abandoned.
    task automatic run_instr(input logic [31:0] ins, input bit fix, input logic [3:0] ff,
                             input int abort_at);
        int ph[$];
        logic ce;
        ph.push_back(P_F);
        ph.push_back(P_D);
        case (ins[27:26])
            2'b01: begin
                ph.push_back(P_MA);
                if (ins[20]) begin ph.push_back(P_MR); ph.push_back(P_MWB); end
                else ph.push_back(P_MW);
            end
            2'b00: begin ph.push_back(ins[25] ? P_EI : P_ER); ph.push_back(P_AWB); end
            2'b10: ph.push_back(P_BR);
            default: ;
        endcase
        for (int i = 0; i < ph.size(); i++) begin
            @(negedge clk);
            if (i == 0) Instr = ins;
            ALUFlags = fix ? ff : 4'($urandom);
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_memwrite", {31'b0, MemWrite}, 32'b0);
                check("abort_outs", {11'b0, obs}, {11'b0, exp_vec(P_F, ins, 1'b0) & ~WEN_MASK});
                mflags = 4'b0000;
                @(posedge clk);
                @(posedge clk);
                #2 reset = 1'b1;
                return;
            end
            #1;
            ce = cond_ok(ins[31:28], mflags);
            check($sformatf("%08h_ph%0d", ins, ph[i]), {11'b0, obs}, {11'b0, exp_vec(ph[i], ins, ce)});
            if ((ph[i] == P_ER || ph[i] == P_EI) && ce && (ins[20] || is_cmpop(ins))) begin
                mflags[3:2] = ALUFlags[3:2];
                if (!is_movx(ins) && !is_mulop(ins) &&
                    (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010 || ins[24:21] == 4'b1010))
                    mflags[1:0] = ALUFlags[1:0];
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [3:0] cmds [6] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1101};
        ins = $urandom;
        if ($urandom_range(0, 2) == 0) ins[31:28] = 4'b1110;
        case ($urandom_range(0, 6))
            0: begin ins[27:26] = 2'b01; end
            1, 2: begin
                ins[27:26] = 2'b00;
                ins[24:21] = cmds[$urandom_range(0, 5)];
            end
            3: begin
                ins[27:25] = 3'b000;
                ins[7:4]   = 4'b1001;
            end
            4: begin ins[27:26] = 2'b10; end
            5: begin ins[27:26] = 2'b11; end
            default: begin ins[27:20] = $urandom_range(0, 1) ? 8'h34 : 8'h30; end
        endcase
        return ins;
    endfunction

    initial begin
        reset    = 1'b0;
        Instr    = 32'hE0821003;
        ALUFlags = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("reset_outs", {11'b0, obs}, {11'b0, exp_vec(P_F, Instr, 1'b0) & ~WEN_MASK});
        end
        @(posedge clk);
        #2 reset = 1'b1;

        run_instr(32'hE0821003, 0, 4'b0, -1);     // ADD
        run_instr(32'hE5912004, 0, 4'b0, -1);     // LDR
        run_instr(32'hE0521003, 1, 4'b0000, -1);  // SUBS -> Z=0
        run_instr(32'h0A000002, 0, 4'b0, -1);     // BEQ not taken
        run_instr(32'hE0521003, 1, 4'b0100, -1);  // SUBS -> Z=1
        run_instr(32'h0A000002, 0, 4'b0, -1);     // BEQ taken
        run_instr(32'hE0832291, 0, 4'b0, -1);     // UMULL
        run_instr(32'hE0020091, 0, 4'b0, -1);     // MUL
        run_instr(32'hE3412234, 0, 4'b0, -1);     // MOVT
        run_instr(32'hE3012234, 0, 4'b0, -1);     // MOVM
        run_instr(32'hEF000000, 0, 4'b0, -1);     // Op=11
        run_instr(32'hE0521003, 1, 4'b1111, -1);  // SUBS -> NZCV=1111
        run_instr(32'hE5812000, 0, 4'b0, 3);      // STR, reset in MEMWRITE
        run_instr(32'h0A000002, 0, 4'b0, -1);     // EQ fails with flags 0000
        run_instr(32'h2A000002, 0, 4'b0, -1);     // CS fails
        run_instr(32'h5A000002, 0, 4'b0, -1);     // PL passes
        run_instr(32'hFA000002, 0, 4'b0, -1);     // NV never passes

        for (int n = 0; n < 300; n++)
            run_instr(rand_instr(), 0, 4'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
